// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and a constant-foldable ceiling-log2 used to size bit counters.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/full_adder_mux.sv
// One-bit full adder built from 2:1 multiplexers around a single XOR
// propagate term.
module full_adder_mux (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic prop;

  assign prop = A ^ B;
  assign S    = Cin ? ~prop : prop;
  // Propagate passes the incoming carry; otherwise A==B and A is the carry.
  assign Cout = prop ? Cin : A;

endmodule

// File: rtl/serial_adder_mux.sv
// Bit-serial N-bit adder: one mux full-adder cell and a carry flop process
// A + B + Cin LSB-first, one bit per clock, behind a start/busy/done handshake.
module serial_adder_mux
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  localparam int CW = clog2(N + 1);

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          cell_s;
  logic          cell_c;
  logic [N-1:0]  sum_shift;

  full_adder_mux u_cell (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .S    (cell_s),
    .Cout (cell_c)
  );

  // New sum bit enters at the MSB so that after N shifts bit 0 is the LSB.
  generate
    if (N == 1) begin : g_sum_w1
      assign sum_shift = cell_s;
    end else begin : g_sum_wn
      assign sum_shift = {cell_s, Sum[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= Cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          Sum   <= sum_shift;
          carry <= cell_c;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            Cout  <= cell_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_mux.sv
// Randomised and directed checks of serial_adder_mux against an arithmetic
// reference (A + B + Cin) plus handshake timing expectations.
module tb_serial_adder_mux;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  int checks;
  int errors;

  serial_adder_mux #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits from just after an edge until done is seen; n counts edges waited.
  task automatic wait_done(output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    while (!done && n < 32) begin
      if (!busy) busy_low = busy_low + 1;
      @(posedge clk);
      #1;
      n = n + 1;
    end
  endtask

  task automatic scramble_inputs();
    a   = 4'($urandom);
    b   = 4'($urandom);
    cin = 1'($urandom);
  endtask

  // One full transaction with an idle cycle afterwards.
  task automatic run_add(input string tag, input logic [N-1:0] av,
                         input logic [N-1:0] bv, input logic cv);
    int n;
    int busy_low;
    int unsigned exp;
    exp = int'(av) + int'(bv) + int'(cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    wait_done(n, busy_low);
    check({tag, "_latency"}, n, N);
    check({tag, "_busy_low_in_run"}, busy_low, 0);
    check({tag, "_result"}, {cout, sum}, exp);
    check({tag, "_busy_at_done"}, busy, 0);
    $display("add %s A=%0d B=%0d Cin=%0d -> Cout=%0d Sum=%0d (exp %0d) lat=%0d",
             tag, av, bv, cv, cout, sum, exp, n);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n;
    int busy_low;
    int done_cnt;
    checks = 0;
    errors = 0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    rst    = 1'b1;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    $display("reset busy=%0d done=%0d Sum=%0d Cout=%0d", busy, done, sum, cout);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_add("zero", 4'h0, 4'h0, 1'b0);
    run_add("carry_chain", 4'b0111, 4'b0001, 1'b0);
    run_add("overflow", 4'hF, 4'h1, 1'b0);
    run_add("all_ones_cin", 4'hF, 4'hF, 1'b1);

    // Every operand combination.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      int unsigned exp;
      v = 9'(i);
      exp = int'(v[8:5]) + int'(v[4:1]) + int'(v[0]);
      @(negedge clk);
      a = v[8:5]; b = v[4:1]; cin = v[0]; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      scramble_inputs();
      wait_done(n, busy_low);
      check("exh_result", {cout, sum}, exp);
      check("exh_latency", n, N);
      $display("exh A=%0d B=%0d Cin=%0d -> %0d (exp %0d)", v[8:5], v[4:1], v[0], {cout, sum}, exp);
    end

    for (int i = 0; i < 40; i++) begin
      run_add("rand", 4'($urandom), 4'($urandom), 1'($urandom));
    end

    // Start while busy must be ignored.
    @(negedge clk);
    a = 4'h3; b = 4'h4; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 4'hF; b = 4'hF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt = done_cnt + 1;
        check("ignored_start_sum", sum, 4'h7);
        check("ignored_start_cout", cout, 0);
      end
    end
    check("ignored_start_done_count", done_cnt, 1);
    $display("ignore_busy_start Sum=%0d Cout=%0d dones=%0d", sum, cout, done_cnt);

    // Back-to-back: start accepted in the DONE cycle.
    @(negedge clk);
    a = 4'h9; b = 4'h3; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, busy_low);
    check("b2b_first_result", {cout, sum}, 12);
    a = 4'h2; b = 4'h2; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    check("b2b_busy_reentry", busy, 1);
    check("b2b_done_drop", done, 0);
    wait_done(n, busy_low);
    check("b2b_latency", n, N);
    check("b2b_second_result", {cout, sum}, 4);
    $display("back_to_back Sum=%0d Cout=%0d lat=%0d", sum, cout, n);

    // Asynchronous reset two cycles into RUN.
    @(negedge clk);
    a = 4'h9; b = 4'h9; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_cout", cout, 0);
    $display("async_reset busy=%0d done=%0d Sum=%0d Cout=%0d", busy, done, sum, cout);
    @(negedge clk);
    rst = 1'b0;
    run_add("after_reset", 4'h5, 4'h6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_mux.md
Name: serial_adder_mux

Overview:
- Bit-serial N-bit ripple adder built around one mux-based full-adder cell plus a carry flip-flop.
- Computes A + B + Cin LSB-first, one bit per clock, behind a start/busy/done handshake.
- Addition counterpart to the mux-based full subtractor. Gives the arithmetic library a sequential, area-minimal adder for wide operands.

Parameters:
- N, 4, operand width in bits; legal range N >= 1.

Ports:
- clk    input   1  system clock; all state updates on the rising edge.
- rst    input   1  asynchronous, active-high reset.
- start  input   1  request; sampled only when busy=0.
- A      input   N  operand A; captured on the accepted start.
- B      input   N  operand B; captured on the accepted start.
- Cin    input   1  carry-in; captured on the accepted start.
- busy   output  1  high while an addition is in progress.
- done   output  1  one-cycle pulse when Sum/Cout become valid.
- Sum    output  N  result; holds its value until the next accepted start.
- Cout   output  1  final carry; holds its value until the next accepted start.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high (clk, rst).
  - rst=1 forces state IDLE, busy=0, done=0, Sum=0, Cout=0, bit counter=0, carry FF=0, operand shift registers=0.
  - Reset mid-operation aborts the addition with no partial result retained.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch A and B into shift registers, Cin into the carry FF, clear counter, go to RUN.
  - Sum and Cout keep their previous values until the first RUN shift.
- RUN:
  - busy=1.
  - Each edge k+1..k+N feeds the cell with a_sr[0], b_sr[0] and carry.
  - The cell's sum bit shifts into Sum from the MSB side (Sum <= {s, Sum[N-1:1]}); carry FF <= cell carry-out.
  - a_sr and b_sr shift right by one; counter increments.
  - After the edge where counter reaches N-1, next state is DONE and Cout <= final carry.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0; returns to IDLE at the next edge.
  - start=1 while in DONE is accepted exactly as in IDLE (back-to-back operation); the next state is RUN, not IDLE.
- Latency: start accepted at edge k gives done high in the cycle following edge k+N. Throughput is one addition per N+1 cycles.
- start while busy=1 is ignored. No queuing, no effect on the in-flight operation.
- A, B and Cin may change freely after the accepted start; only captured values are used.
- Result width: N+1 bits total ({Cout, Sum}). No overflow flag; unsigned interpretation.
- N=1: RUN lasts one cycle; done appears in the cycle after edge k+1.
- Counter width is $clog2(N+1) bits and never wraps during a valid operation.

Decomposition:
- Shared package (arith_pkg):
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a counter-width function (clog2).
- One sub-module, full_adder_mux:
  - ports A, B, Cin -> S, Cout;
  - S = A^B^Cin implemented as a 2:1 mux selecting on Cin between (A^B) and ~(A^B);
  - Cout implemented as a mux selecting on (A^B) between Cin and A.
- The top level holds the FSM, counter, shift registers and carry FF, and instantiates one full_adder_mux.

Test Plan:
- Reset, then start with A=0, B=0, Cin=0 at edge k -> busy high for edges k+1..k+4, done one-cycle pulse after edge k+4, Sum=4'h0, Cout=0.
- A=4'b0111, B=4'b0001, Cin=0 -> Sum=4'b1000, Cout=0. Then A=4'hF, B=4'h1, Cin=0 -> Sum=4'h0, Cout=1.
- A=4'hF, B=4'hF, Cin=1 -> Sum=4'hF, Cout=1. Then exhaustively loop all 512 {A,B,Cin} combinations -> {Cout,Sum}==A+B+Cin for each.
- start with A=4'h3, B=4'h4, then a second start with A=4'hF, B=4'hF two cycles later while busy -> second start ignored; result Sum=4'h7, Cout=0; done only once.
- start asserted in the DONE cycle with A=4'h2, B=4'h2 -> immediately re-enters RUN; second done after 4 RUN cycles with Sum=4'h4.
- Assert rst asynchronously (mid-cycle) two cycles into RUN -> busy, done, Sum and Cout go to 0 immediately. A subsequent start with A=4'h5, B=4'h6 -> Sum=4'hB, Cout=0.
